// File: rtl/xbus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbus_arbiter_pkg : shared widths, access-length default and FSM encoding   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package xbus_arbiter_pkg;

    localparam int XB_ADDR_W  = 16;
    localparam int XB_DATA_W  = 32;
    localparam int XB_ACC_CYC = 2;
    localparam int XB_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } xb_state_e;

    // Saturating decrement keeps the access counter from wrapping below zero.
    function automatic logic [XB_CNT_W-1:0] cnt_dec(input logic [XB_CNT_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbus_arbiter_if : two-master request bus plus decoder-side access signals  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface xbus_arbiter_if
    import xbus_arbiter_pkg::*;
#(
    parameter int ADDR_W = XB_ADDR_W
) ();

    logic                 m0_req;
    logic [ADDR_W-1:0]    m0_addr;
    logic                 m0_we;
    logic [XB_DATA_W-1:0] m0_wdata;
    logic                 m0_ack;
    logic [XB_DATA_W-1:0] m0_rdata;
    logic                 m0_err;

    logic                 m1_req;
    logic [ADDR_W-1:0]    m1_addr;
    logic                 m1_we;
    logic [XB_DATA_W-1:0] m1_wdata;
    logic                 m1_ack;
    logic [XB_DATA_W-1:0] m1_rdata;
    logic                 m1_err;

    logic [ADDR_W-1:0]    addr;
    logic                 sel;
    logic                 we;
    logic [XB_DATA_W-1:0] data_to_wr;
    logic [XB_DATA_W-1:0] data_to_rd;
    logic                 trap_sel;
    logic                 owner;

    // Arbiter view: accepts master requests, drives the decoder side.
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        input  data_to_rd, trap_sel,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output addr, sel, we, data_to_wr, owner
    );

    // Environment view: masters plus the external address decoder.
    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata,
        output m1_req, m1_addr, m1_we, m1_wdata,
        output data_to_rd, trap_sel,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err,
        input  addr, sel, we, data_to_wr, owner
    );

endinterface
`default_nettype wire

// File: rtl/xrr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xrr_arb2 : combinational two-input round-robin grant (one-hot output)      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xrr_arb2 (
    input  wire logic [1:0] req_i,
    input  wire logic       last_i,
    output logic      [1:0] gnt_o
);

    // On contention the master that was not granted last wins.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
        gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
    end

endmodule
`default_nettype wire

// File: rtl/xbus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbus_arbiter : two-master round-robin bus arbiter with fixed-length access |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = XB_ADDR_W,
    parameter int ACC_CYC = XB_ACC_CYC
) (
    input wire logic      clk,
    input wire logic      rst,
    xbus_arbiter_if.slave bus
);

    xb_state_e            state_q, state_d;
    logic [XB_CNT_W-1:0]  cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [XB_DATA_W-1:0] wdata_q, wdata_d;
    logic [XB_DATA_W-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       in_busy;
    logic       in_resp;
    logic       ack0;
    logic       ack1;

    assign req = {bus.m1_req, bus.m0_req};

    xrr_arb2 u_rr (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    // last_q resets to 1 so that m0 wins the first contended arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = gnt[1];
                    last_d  = gnt[1];
                    addr_d  = gnt[1] ? bus.m1_addr  : bus.m0_addr;
                    we_d    = gnt[1] ? bus.m1_we    : bus.m0_we;
                    wdata_d = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
                    cnt_d   = XB_CNT_W'(ACC_CYC - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.data_to_rd;
                    err_d   = bus.trap_sel;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_dec(cnt_q);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_busy = (state_q == ST_BUSY);
    assign in_resp = (state_q == ST_RESP);
    assign ack0    = in_resp & ~owner_q;
    assign ack1    = in_resp &  owner_q;

    assign bus.sel        = in_busy;
    assign bus.addr       = addr_q;
    assign bus.we         = we_q;
    assign bus.data_to_wr = wdata_q;
    assign bus.owner      = owner_q;

    // Read data is only presented on a read ack; writes and idle masters see zero.
    assign bus.m0_ack   = ack0;
    assign bus.m0_rdata = (ack0 & ~we_q) ? rdata_q : '0;
    assign bus.m0_err   = ack0 & err_q;
    assign bus.m1_ack   = ack1;
    assign bus.m1_rdata = (ack1 & ~we_q) ? rdata_q : '0;
    assign bus.m1_err   = ack1 & err_q;

endmodule
`default_nettype wire
